zero_edge_scheduler: RTL and testbench
======================================

ZERO_EDGE_SCHEDULER -- requirements
Module: zero_edge_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clock is the single clock, and reset is asynchronous and active-low.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 req0, req1  input  1 each  requester word-ready strobes, level, held until the matching gnt.
REQ-005 data0, data1  input  8 each  requester words, valid while the matching req is high.
REQ-006 gnt0, gnt1  output  1 each  one-cycle accept pulses, mutually exclusive.
REQ-007 busy  output  1  high in every non-IDLE state.
REQ-008 done  output  1  one-cycle result-valid pulse.
REQ-009 done_id  output  1  channel of the reported word (0/1), valid with done.
REQ-010 zero_count  output  3  count of detected 1-to-0 transitions in the word, valid with done.

Function
REQ-011 The block SHALL time-share one serial zero detector between two requesters, feeding each accepted word LSB first, one bit per clock.
REQ-012 Detector rule: y SHALL be 1 exactly when the current bit is 0 and the previous bit of the same word was 1; the first bit of every word SHALL see a cleared history (y=0).
REQ-013 The FSM SHALL have states IDLE, SHIFT and REPORT: IDLE goes to SHIFT on any req; SHIFT goes to REPORT after the 8th bit; REPORT goes to IDLE unconditionally.
REQ-014 In IDLE on the edge where a req is seen, the block SHALL latch the winner's data, clear the detector history and the counter, and assert the winner's gnt for the next cycle, which is the first SHIFT cycle.
REQ-015 Arbitration SHALL be round-robin: with both reqs high, the channel not granted last wins; after reset channel 0 has priority.
REQ-016 A single requesting channel SHALL be granted regardless of last-grant history.
REQ-017 req inputs SHALL be ignored outside IDLE, and data SHALL NOT be re-sampled after the latch edge.
REQ-018 SHIFT SHALL last exactly 8 cycles with bit index 0..7, incrementing the 3-bit counter on each y=1; the maximum possible value is 4, so the counter needs no saturation.
REQ-019 Latency: req sampled at edge N gives gnt high in cycle N+1, SHIFT cycles N+1..N+8, and done high in cycle N+9; the next grant is sampled no earlier than edge N+10.
REQ-020 zero_count and done_id SHALL hold their last reported values until the next REPORT; done and gnt SHALL be low in all other cycles.
REQ-021 A req that stays high after its gnt SHALL be treated as a new request at the next IDLE, subject to round-robin.

Reset
REQ-022 Reset SHALL force: state=IDLE, gnt0=gnt1=0, busy=0, done=0, done_id=0, zero_count=0, detector history cleared, bit index 0, and last-grant=1 (channel 0 favoured).
REQ-023 Reset asserted mid-SHIFT or mid-REPORT SHALL abort the word silently, with no done pulse, and the aborted requester SHALL re-request.
REQ-024 The first grant after reset deassertion SHALL occur no earlier than the first rising edge with reset high.

Structure
REQ-025 The shared package SHALL hold the state encodings (IDLE=2'b00, SHIFT=2'b01, REPORT=2'b10), WORD_W=8, CNT_W=3, and the channel IDs CH0=0, CH1=1.
REQ-026 The Mealy detector SHALL be a separate sub-module, zero_edge_fsm, with inputs clock, reset, clr (synchronous history clear) and x_in, and output y_out (combinational Mealy output); the arbiter, shift register and counter SHALL live in the top level.
REQ-027 The unused state encoding 2'b11 SHALL return to IDLE.

Verification
REQ-028 Reset, then req0 with data0=8'h55 -> gnt0 in cycle 1, done in cycle 9, zero_count=4, done_id=0.
REQ-029 req1 with data1=8'h0F -> zero_count=1; req1 with data1=8'hFF -> zero_count=0; req0 with data0=8'h80 -> zero_count=0; req0 with data0=8'h01 -> zero_count=1.
REQ-030 req0 and req1 both high from reset, held until their gnt -> ch0 served first, ch1 second, then alternating while both stay high; gnt never overlaps.
REQ-031 Reset pulsed low during SHIFT bit 4 -> outputs return to reset values and no done; the word is re-requested after reset and the full result is reported.
REQ-032 req1 raised and changed in mid-SHIFT of a ch0 word -> ch0 result is unaffected, and ch1 is granted in the IDLE cycle following REPORT.
REQ-033 The bench SHALL check with a reference model that busy is high for exactly 9 cycles per word and that done is never high in the same cycle as any gnt.

Source files
------------

// File: rtl/zero_edge_scheduler_pkg.sv
// Shared types and constants for the two-channel serial 1-to-0 edge counter.
package zero_edge_scheduler_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned IDX_W  = $clog2(WORD_W);

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StShift  = 2'b01,
    StReport = 2'b10
  } state_e;

  // Detector history: whether the previous bit of the word was 1.
  typedef enum logic {
    DetLow  = 1'b0,
    DetHigh = 1'b1
  } det_state_e;

endpackage

// File: rtl/zero_edge_fsm.sv
// Mealy 1-to-0 transition detector: y_out is high when x_in is 0 and the previous bit was 1.
module zero_edge_fsm
  import zero_edge_scheduler_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic x_in,
  output logic y_out
);

  det_state_e st_q, st_d;

  // History register; clr wipes it so the first bit of a word never fires.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q <= DetLow;
    end else begin
      st_q <= st_d;
    end
  end

  // Next history and combinational Mealy output.
  always_comb begin
    st_d  = x_in ? DetHigh : DetLow;
    if (clr) begin
      st_d = DetLow;
    end
    y_out = (st_q == DetHigh) && !x_in;
  end

endmodule

// File: rtl/zero_edge_scheduler.sv
// Round-robin time-sharing of one serial 1-to-0 detector between two word requesters.
module zero_edge_scheduler
  import zero_edge_scheduler_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [WORD_W-1:0] data0,
  input  logic [WORD_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic [CNT_W-1:0]  zero_count
);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q;
  logic [IDX_W-1:0]   bit_idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_next;
  logic               cur_ch_q;
  logic               last_q;
  logic               gnt0_q, gnt1_q;
  logic               done_id_q;
  logic [CNT_W-1:0]   zero_count_q;
  logic               accept;
  logic               win;
  logic               last_bit;
  logic               det_clr;
  logic               det_y;

  // History is held clear outside SHIFT, so the latch edge always starts a word fresh.
  assign det_clr  = (state_q != StShift);
  assign last_bit = (bit_idx_q == IDX_W'(WORD_W - 1));
  assign cnt_next = cnt_q + CNT_W'(det_y);

  zero_edge_fsm u_det (
    .clock (clock),
    .reset (reset),
    .clr   (det_clr),
    .x_in  (shreg_q[0]),
    .y_out (det_y)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and round-robin winner; requests only matter in IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    win     = CH0;
    case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          accept  = 1'b1;
          state_d = StShift;
          // Contention goes to the channel not granted last; otherwise the lone requester.
          win     = (req0 && req1) ? ~last_q : req1;
        end
      end
      StShift: begin
        if (last_bit) begin
          state_d = StReport;
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath: latch winner, shift LSB first, count edges, capture result on the last bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      cnt_q        <= '0;
      cur_ch_q     <= CH0;
      last_q       <= CH1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done_id_q    <= CH0;
      zero_count_q <= '0;
    end else begin
      gnt0_q <= accept && (win == CH0);
      gnt1_q <= accept && (win == CH1);
      if (accept) begin
        shreg_q   <= (win == CH1) ? data1 : data0;
        bit_idx_q <= '0;
        cnt_q     <= '0;
        cur_ch_q  <= win;
        last_q    <= win;
      end else if (state_q == StShift) begin
        shreg_q   <= shreg_q >> 1;
        bit_idx_q <= bit_idx_q + 1'b1;
        cnt_q     <= cnt_next;
        if (last_bit) begin
          zero_count_q <= cnt_next;
          done_id_q    <= cur_ch_q;
        end
      end
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StReport);
  assign done_id    = done_id_q;
  assign zero_count = zero_count_q;

endmodule

// File: tb/tb_zero_edge_scheduler.sv
// Directed plus randomized bench for zero_edge_scheduler with a word-level reference model.
module tb_zero_edge_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, busy, done, done_id;
  logic [2:0] zero_count;

  int checks = 0;
  int errors = 0;
  int busy_run = 0;

  zero_edge_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .data0      (data0),
    .data1      (data1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .zero_count (zero_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Number of positions where a 1 is immediately followed (toward the MSB) by a 0.
  function automatic logic [7:0] ref_count(input logic [7:0] w);
    int n = 0;
    for (int i = 1; i < 8; i++) if (w[i-1] && !w[i]) n++;
    return 8'(n);
  endfunction

  // Cycle monitor: no done with a grant, no overlapping grants, 9-cycle busy windows.
  always @(negedge clock) begin
    if (!reset) begin
      busy_run = 0;
    end else begin
      check("done_vs_gnt", {7'd0, done && (gnt0 || gnt1)}, 8'd0);
      check("gnt_overlap", {7'd0, gnt0 && gnt1}, 8'd0);
      if (busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("busy_len", 8'(busy_run), 8'd9);
        busy_run = 0;
      end
    end
  end

  // Expects the word requested before the next edge to run its full 10-cycle course.
  task automatic expect_word(input logic ch, input logic [7:0] word, input bit intrude);
    logic [7:0] exp_cnt;
    exp_cnt = ref_count(word);
    @(posedge clock);
    @(negedge clock);
    check("gnt_mine", {7'd0, ch ? gnt1 : gnt0}, 8'd1);
    check("gnt_other", {7'd0, ch ? gnt0 : gnt1}, 8'd0);
    check("busy_first", {7'd0, busy}, 8'd1);
    if (ch) begin req1 = 1'b0; data1 = 8'($urandom); end
    else    begin req0 = 1'b0; data0 = 8'($urandom); end
    for (int i = 1; i < 8; i++) begin
      @(negedge clock);
      if (intrude && i == 3) begin req1 = 1'b1; data1 = 8'($urandom); end
      if (intrude && i == 5) data1 = 8'hAA;
      check("shift_quiet", {4'd0, done, gnt0, gnt1, busy}, 8'b0001);
    end
    @(negedge clock);
    check("done", {7'd0, done}, 8'd1);
    check("done_id", {7'd0, done_id}, {7'd0, ch});
    check("zero_count", {5'd0, zero_count}, exp_cnt);
    check("report_busy", {7'd0, busy}, 8'd1);
    @(negedge clock);
    check("idle_done", {6'd0, done, busy}, 8'd0);
    check("hold_count", {5'd0, zero_count}, exp_cnt);
    check("hold_id", {7'd0, done_id}, {7'd0, ch});
  endtask

  initial begin
    logic       ch_r;
    logic [7:0] d_r;
    logic       rr_last;
    logic       exp_ch;
    logic       got;
    logic [7:0] pend [2];

    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    repeat (2) @(negedge clock);
    check("rst_outputs", {3'd0, busy, gnt0, gnt1, done, done_id}, 8'd0);
    check("rst_count", {5'd0, zero_count}, 8'd0);
    reset = 1'b1;

    // Directed words.
    req0 = 1'b1; data0 = 8'h55; expect_word(1'b0, 8'h55, 1'b0);
    req1 = 1'b1; data1 = 8'h0F; expect_word(1'b1, 8'h0F, 1'b0);
    req1 = 1'b1; data1 = 8'hFF; expect_word(1'b1, 8'hFF, 1'b0);
    req0 = 1'b1; data0 = 8'h80; expect_word(1'b0, 8'h80, 1'b0);
    req0 = 1'b1; data0 = 8'h01; expect_word(1'b0, 8'h01, 1'b0);

    // Random single-channel words; a lone requester wins whatever the history.
    for (int k = 0; k < 16; k++) begin
      ch_r = 1'($urandom_range(0, 1));
      d_r  = 8'($urandom);
      if (ch_r) begin req1 = 1'b1; data1 = d_r; end
      else      begin req0 = 1'b1; data0 = d_r; end
      expect_word(ch_r, d_r, 1'b0);
    end

    // ch1 arrives and changes data mid-word; served right after the ch0 report.
    req0 = 1'b1; data0 = 8'h55; expect_word(1'b0, 8'h55, 1'b1);
    expect_word(1'b1, 8'hAA, 1'b0);

    // Reset during bit 4 aborts silently; the word is re-requested and completes.
    req0 = 1'b1; data0 = 8'h55;
    @(posedge clock);
    @(negedge clock);
    check("abort_gnt", {7'd0, gnt0}, 8'd1);
    req0 = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0; req0 = 1'b1;
    #1;
    check("abort_outputs", {3'd0, busy, gnt0, gnt1, done, done_id}, 8'd0);
    check("abort_count", {5'd0, zero_count}, 8'd0);
    @(posedge clock);
    @(negedge clock);
    check("abort_hold", {3'd0, busy, gnt0, gnt1, done, done_id}, 8'd0);
    reset = 1'b1;
    expect_word(1'b0, 8'h55, 1'b0);

    // Both requesters held from reset: ch0 first, then strict alternation.
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
    data0 = 8'($urandom); data1 = 8'($urandom);
    pend[0] = data0; pend[1] = data1;
    rr_last = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int w = 0; w < 6; w++) begin
      exp_ch = ~rr_last;
      got = 1'b0;
      for (int t = 0; t < 12 && !got; t++) begin
        @(negedge clock);
        if (gnt0 || gnt1) got = 1'b1;
      end
      check("rr_granted", {7'd0, got}, 8'd1);
      check("rr_gnt1", {7'd0, gnt1}, {7'd0, exp_ch});
      check("rr_gnt0", {7'd0, gnt0}, {7'd0, ~exp_ch});
      d_r = pend[exp_ch];
      rr_last = exp_ch;
      if (exp_ch) begin data1 = 8'($urandom); pend[1] = data1; end
      else        begin data0 = 8'($urandom); pend[0] = data0; end
      repeat (8) @(negedge clock);
      check("rr_done", {7'd0, done}, 8'd1);
      check("rr_id", {7'd0, done_id}, {7'd0, exp_ch});
      check("rr_count", {5'd0, zero_count}, ref_count(d_r));
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (12) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
